// File: rtl/ps2_cmd_seq.sv
// Host-side PS/2 command sequencer: sends a one- or two-byte command, waits for the ACK,
// resends the byte on RESEND, and emits exactly one done or error pulse per accepted command.
//   state    | meaning
//   IDLE     | waiting for cmd_req
//   SEND     | selected byte on din, waiting for tx_idle before strobing wr_ps2
//   WAIT_TX  | frame in flight, waiting for tx_done_tick (timed)
//   WAIT_ACK | waiting for the device reply byte (timed)
module ps2_cmd_seq #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       cmd_req_i,
    input  logic [7:0] cmd_byte_i,
    input  logic       has_arg_i,
    input  logic [7:0] arg_byte_i,
    input  logic       tx_idle_i,
    input  logic       tx_done_tick_i,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_dout_i,
    output logic       wr_ps2_o,
    output logic [7:0] din_o,
    output logic       busy_o,
    output logic       cmd_done_tick_o,
    output logic       cmd_err_tick_o,
    output logic [1:0] err_code_o
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SEND     = 2'd1;
    localparam logic [1:0] S_WAIT_TX  = 2'd2;
    localparam logic [1:0] S_WAIT_ACK = 2'd3;

    localparam logic [7:0] RX_ACK    = 8'hFA;
    localparam logic [7:0] RX_RESEND = 8'hFE;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RETRY   = 2'b10;
    localparam logic [1:0] ERR_REPLY   = 2'b11;

    logic [1:0]    state_q, state_d;
    logic          byte_sel_q, byte_sel_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic          has_arg_q, has_arg_d;
    logic          wr_q, wr_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    always_comb begin
        state_d    = state_q;
        byte_sel_d = byte_sel_q;
        retry_d    = retry_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        has_arg_d  = has_arg_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_req_i) begin
                    cmd_d      = cmd_byte_i;
                    arg_d      = arg_byte_i;
                    has_arg_d  = has_arg_i;
                    byte_sel_d = 1'b0;
                    retry_d    = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_idle_i) begin
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done_tick_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end else if (cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WAIT_ACK: begin
                // A reply landing on the timeout cycle still counts as a reply.
                if (rx_done_tick_i) begin
                    if (rx_dout_i == RX_ACK) begin
                        if (!byte_sel_q && has_arg_q) begin
                            byte_sel_d = 1'b1;
                            retry_d    = '0;
                            state_d    = S_SEND;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (rx_dout_i == RX_RESEND) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RW'(1);
                            state_d = S_SEND;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RETRY;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_REPLY;
                        state_d    = S_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            byte_sel_q <= 1'b0;
            retry_q    <= '0;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            arg_q      <= 8'h00;
            has_arg_q  <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            byte_sel_q <= byte_sel_d;
            retry_q    <= retry_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            has_arg_q  <= has_arg_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign wr_ps2_o        = wr_q;
    assign din_o           = byte_sel_q ? arg_q : cmd_q;
    assign busy_o          = (state_q != S_IDLE);
    assign cmd_done_tick_o = done_q;
    assign cmd_err_tick_o  = err_q;
    assign err_code_o      = err_code_q;

endmodule

// File: tb/tb_ps2_cmd_seq.sv
// Directed bench for ps2_cmd_seq with hand-computed expectations (TIMEOUT_CYCLES=100, MAX_RETRY=3).
module tb_ps2_cmd_seq;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       cmd_req_i = 1'b0;
    logic [7:0] cmd_byte_i = 8'h00;
    logic       has_arg_i = 1'b0;
    logic [7:0] arg_byte_i = 8'h00;
    logic       tx_idle_i = 1'b1;
    logic       tx_done_tick_i = 1'b0;
    logic       rx_done_tick_i = 1'b0;
    logic [7:0] rx_dout_i = 8'h00;
    logic       wr_ps2_o;
    logic [7:0] din_o;
    logic       busy_o;
    logic       cmd_done_tick_o;
    logic       cmd_err_tick_o;
    logic [1:0] err_code_o;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_cmd_seq #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_req_i(cmd_req_i), .cmd_byte_i(cmd_byte_i),
        .has_arg_i(has_arg_i), .arg_byte_i(arg_byte_i),
        .tx_idle_i(tx_idle_i), .tx_done_tick_i(tx_done_tick_i),
        .rx_done_tick_i(rx_done_tick_i), .rx_dout_i(rx_dout_i),
        .wr_ps2_o(wr_ps2_o), .din_o(din_o), .busy_o(busy_o),
        .cmd_done_tick_o(cmd_done_tick_o), .cmd_err_tick_o(cmd_err_tick_o),
        .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (wr_ps2_o === 1'b1) wr_cnt++;
        if (cmd_done_tick_o === 1'b1) done_cnt++;
        if (cmd_err_tick_o === 1'b1) err_cnt++;
        if (cmd_done_tick_o === 1'b1 && cmd_err_tick_o === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic h, input logic [7:0] a);
        cmd_req_i  = 1'b1;
        cmd_byte_i = c;
        has_arg_i  = h;
        arg_byte_i = a;
        tick();
        cmd_req_i  = 1'b0;
        check("busy_after_req", busy_o, 1'b1);
        check("din_at_send", din_o, c);
    endtask

    // Entered while the DUT is in SEND; leaves one cycle after the reply edge.
    task automatic do_byte(input logic [7:0] exp_din, input logic [7:0] reply);
        tick();
        cmd_req_i = 1'b0;
        check("wr_strobe", wr_ps2_o, 1'b1);
        check("din_at_wr", din_o, exp_din);
        tick();
        check("wr_one_cycle", wr_ps2_o, 1'b0);
        tx_done_tick_i = 1'b1;
        tick();
        tx_done_tick_i = 1'b0;
        rx_done_tick_i = 1'b1;
        rx_dout_i      = reply;
        tick();
        rx_done_tick_i = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_busy", busy_o, 1'b0);
        check("rst_wr", wr_ps2_o, 1'b0);
        check("rst_din", din_o, 8'h00);
        check("rst_err_code", err_code_o, 2'b00);
        reset_n_i = 1'b1;
        tick();

        // single-byte command
        wr_cnt = 0;
        issue(8'hF4, 1'b0, 8'h00);
        check("single_no_wr_yet", wr_ps2_o, 1'b0);
        do_byte(8'hF4, 8'hFA);
        check("single_done", cmd_done_tick_o, 1'b1);
        check("single_busy_low", busy_o, 1'b0);
        check("single_no_err", cmd_err_tick_o, 1'b0);
        tick();
        check("single_done_pulse", cmd_done_tick_o, 1'b0);
        check("single_wr_count", wr_cnt, 1);

        // stray reply in IDLE is ignored
        rx_done_tick_i = 1'b1;
        rx_dout_i      = 8'hFA;
        tick();
        rx_done_tick_i = 1'b0;
        check("idle_stray_done", cmd_done_tick_o, 1'b0);
        check("idle_stray_busy", busy_o, 1'b0);

        // two-byte command, with a request dropped while busy
        wr_cnt = 0;
        issue(8'hED, 1'b1, 8'h02);
        do_byte(8'hED, 8'hFA);
        check("two_no_early_done", cmd_done_tick_o, 1'b0);
        check("two_busy_mid", busy_o, 1'b1);
        check("two_din_arg", din_o, 8'h02);
        cmd_req_i  = 1'b1;
        cmd_byte_i = 8'h55;
        has_arg_i  = 1'b0;
        do_byte(8'h02, 8'hFA);
        check("two_done", cmd_done_tick_o, 1'b1);
        check("two_busy_low", busy_o, 1'b0);
        check("two_wr_count", wr_cnt, 2);
        tick();
        check("dropped_req_idle", busy_o, 1'b0);

        // resend recovery
        wr_cnt = 0;
        issue(8'hFF, 1'b0, 8'h00);
        do_byte(8'hFF, 8'hFE);
        check("resend1_busy", busy_o, 1'b1);
        check("resend1_no_err", cmd_err_tick_o, 1'b0);
        do_byte(8'hFF, 8'hFE);
        check("resend2_busy", busy_o, 1'b1);
        do_byte(8'hFF, 8'hFA);
        check("resend_done", cmd_done_tick_o, 1'b1);
        check("resend_no_err", cmd_err_tick_o, 1'b0);
        check("resend_wr_count", wr_cnt, 3);
        tick();

        // retry exhaustion
        wr_cnt = 0;
        issue(8'hF5, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            do_byte(8'hF5, 8'hFE);
            check("exhaust_retrying", busy_o, 1'b1);
        end
        do_byte(8'hF5, 8'hFE);
        check("exhaust_err", cmd_err_tick_o, 1'b1);
        check("exhaust_code", err_code_o, 2'b10);
        check("exhaust_no_done", cmd_done_tick_o, 1'b0);
        check("exhaust_busy_low", busy_o, 1'b0);
        check("exhaust_wr_count", wr_cnt, 4);
        tick();
        check("exhaust_err_pulse", cmd_err_tick_o, 1'b0);

        // timeout in WAIT_ACK: error exactly 100 cycles after entry
        issue(8'hF2, 1'b0, 8'h00);
        tick();
        tick();
        tx_done_tick_i = 1'b1;
        tick();
        tx_done_tick_i = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        check("to_ack_not_yet", cmd_err_tick_o, 1'b0);
        check("to_ack_busy", busy_o, 1'b1);
        tick();
        check("to_ack_err", cmd_err_tick_o, 1'b1);
        check("to_ack_code", err_code_o, 2'b01);
        check("to_ack_busy_low", busy_o, 1'b0);
        tick();

        // reply on the timeout cycle wins
        issue(8'hF3, 1'b0, 8'h00);
        tick();
        tick();
        tx_done_tick_i = 1'b1;
        tick();
        tx_done_tick_i = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        rx_done_tick_i = 1'b1;
        rx_dout_i      = 8'hFA;
        tick();
        rx_done_tick_i = 1'b0;
        check("race_done", cmd_done_tick_o, 1'b1);
        check("race_no_err", cmd_err_tick_o, 1'b0);
        check("code_kept_on_success", err_code_o, 2'b01);
        tick();

        // unexpected reply
        issue(8'hF4, 1'b0, 8'h00);
        do_byte(8'hF4, 8'hAA);
        check("unexp_err", cmd_err_tick_o, 1'b1);
        check("unexp_code", err_code_o, 2'b11);
        tick();

        // timeout in WAIT_TX; a reply during WAIT_TX is ignored
        issue(8'hF6, 1'b0, 8'h00);
        tick();
        for (int i = 1; i < 100; i++) begin
            rx_done_tick_i = (i == 10);
            rx_dout_i      = 8'hFA;
            tick();
        end
        rx_done_tick_i = 1'b0;
        check("to_tx_not_yet", cmd_err_tick_o, 1'b0);
        check("to_tx_busy", busy_o, 1'b1);
        tick();
        check("to_tx_err", cmd_err_tick_o, 1'b1);
        check("to_tx_code", err_code_o, 2'b01);
        tick();

        // reset in WAIT_ACK
        issue(8'hF4, 1'b0, 8'h00);
        tick();
        tick();
        tx_done_tick_i = 1'b1;
        tick();
        tx_done_tick_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_code", err_code_o, 2'b00);
        check("rst_mid_din", din_o, 8'h00);
        tick();
        reset_n_i = 1'b1;
        rx_done_tick_i = 1'b1;
        rx_dout_i      = 8'hFA;
        tick();
        rx_done_tick_i = 1'b0;
        check("rst_no_done", cmd_done_tick_o, 1'b0);
        check("rst_no_err", cmd_err_tick_o, 1'b0);
        wr_cnt = 0;
        issue(8'hF4, 1'b0, 8'h00);
        do_byte(8'hF4, 8'hFA);
        check("post_rst_done", cmd_done_tick_o, 1'b1);
        check("post_rst_wr_count", wr_cnt, 1);
        tick();

        check("total_done", done_cnt, 5);
        check("total_err", err_cnt, 4);
        check("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_seq.md
# ps2_cmd_seq

Host-side PS/2 command sequencer sitting directly upstream of the PS/2 transmitter. It accepts a one- or two-byte device command, such as 0xF4 (enable) or 0xED plus an LED argument. It drives the transmitter's write strobe and data byte, then waits for the device's reply from the PS/2 receiver. It handles ACK (0xFA), RESEND (0xFE), retry limits and timeouts, and reports one completion or error pulse per command to the controller above.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: cycles allowed in each wait state before a timeout (20 ms at 100 MHz); counter width is `$clog2(TIMEOUT_CYCLES)`.
- `MAX_RETRY`, default 3: RESEND replies tolerated per byte before the command fails.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_req`  in  1  one-cycle request; sampled only in IDLE.
- `cmd_byte`  in  8  command byte, sampled with `cmd_req`.
- `has_arg`  in  1  command has a second (argument) byte, sampled with `cmd_req`.
- `arg_byte`  in  8  argument byte, sampled with `cmd_req`.
- `tx_idle`  in  1  transmitter is idle.
- `tx_done_tick`  in  1  transmitter finished a frame.
- `rx_done_tick`  in  1  receiver delivered a byte.
- `rx_dout`  in  8  received byte, valid with `rx_done_tick`.
- `wr_ps2`  out  1  registered one-cycle write strobe to the transmitter.
- `din`  out  8  byte to transmit; stable from SEND entry until the next byte is selected.
- `busy`  out  1  high in every state except IDLE.
- `cmd_done_tick`  out  1  one-cycle pulse when the command is fully acknowledged.
- `cmd_err_tick`  out  1  one-cycle pulse when the command fails.
- `err_code`  out  2  holds the cause of the last error until the next error: 01 timeout, 10 retries exhausted, 11 unexpected reply. It is never cleared by a success.

## Operation
- The FSM has four states: IDLE, SEND, WAIT_TX and WAIT_ACK.
- Internal registers:
  - `byte_sel`: 0 selects cmd, 1 selects arg.
  - `retry`: width `$clog2(MAX_RETRY+1)`.
  - Timeout counter.
  - Latched copies of cmd, has_arg and arg.
- IDLE:
  - `busy`=0.
  - On `cmd_req`: latch the inputs, set `byte_sel`=0 and `retry`=0, go to SEND.
  - With no `cmd_req`, all other inputs are ignored, including stray `rx_done_tick` bytes.
- SEND:
  - `din` = the selected byte.
  - When `tx_idle`=1: register `wr_ps2`=1 for the next cycle only, clear the timeout counter, go to WAIT_TX.
  - No timeout applies in SEND.
- WAIT_TX:
  - The timeout counter increments each cycle.
  - `tx_done_tick` → clear the counter, go to WAIT_ACK.
  - Counter reaching `TIMEOUT_CYCLES-1` → error 01.
- WAIT_ACK:
  - The timeout counter increments each cycle.
  - On `rx_done_tick` with `rx_dout`:
    - 0xFA when `byte_sel`=0 and latched `has_arg`=1: set `byte_sel`=1, `retry`=0, go to SEND.
    - 0xFA otherwise: pulse `cmd_done_tick`, go to IDLE.
    - 0xFE when `retry`<`MAX_RETRY`: increment `retry`, go to SEND with the same byte.
    - 0xFE when `retry`=`MAX_RETRY`: error 10.
    - Any other value: error 11.
  - Counter reaching `TIMEOUT_CYCLES-1` with no `rx_done_tick` → error 01.
- Error action:
  - Pulse `cmd_err_tick` and load `err_code` in the same cycle.
  - Go to IDLE.
  - The transmitter is not reset.
- Boundary rules:
  - `cmd_req` while `busy`=1 is dropped and has no side effects.
  - `rx_done_tick` and timeout in the same cycle: the received byte wins.
  - `rx_done_tick` arriving in SEND or WAIT_TX is ignored.
  - `cmd_done_tick` and `cmd_err_tick` are never high together.
  - Exactly one of them pulses per accepted command.
  - With `MAX_RETRY`=0, the first RESEND fails the command.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State IDLE.
  - `wr_ps2`=0, `din`=0x00, `busy`=0, `cmd_done_tick`=0, `cmd_err_tick`=0, `err_code`=00.
  - All counters cleared.
  - Reset mid-command abandons the command silently; no tick is emitted.
- `cmd_req` high at edge N:
  - `busy`=1 and state SEND from N+1.
  - If `tx_idle`=1 during N+1, `wr_ps2`=1 during cycle N+2 only, with `din` already valid since N+1.
- `tx_done_tick` at edge M → WAIT_ACK from M+1.
- `rx_done_tick` with 0xFA at edge K → `cmd_done_tick`=1 during K+1 and `busy`=0 during K+1.
- Each retry or argument byte adds one SEND cycle before the next `wr_ps2`, provided `tx_idle`=1.
- Timeout: `cmd_err_tick` asserts `TIMEOUT_CYCLES` cycles after entering the wait state.

## Test plan
- Single-byte command:
  - Stimulus: `cmd_req`, `cmd_byte`=0xF4, `has_arg`=0; tx idle; tx_done; rx 0xFA.
  - Required: exactly one `wr_ps2` with `din`=0xF4; one `cmd_done_tick`; `busy` falls.
- Two-byte command:
  - Stimulus: 0xED with arg 0x02; two ACKs.
  - Required: `wr_ps2` with `din`=0xED, then with 0x02; one `cmd_done_tick` only after the second ACK.
- Resend recovery:
  - Stimulus: 0xFF; rx 0xFE, 0xFE, then 0xFA.
  - Required: three `wr_ps2` pulses, all with `din`=0xFF; `cmd_done_tick`; no error.
- Retry exhaustion:
  - Stimulus: `MAX_RETRY`=3; every reply 0xFE.
  - Required: four `wr_ps2` pulses, then `cmd_err_tick` with `err_code`=10.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=100; tx_done but no rx reply.
  - Required: `cmd_err_tick` 100 cycles after entering WAIT_ACK, `err_code`=01.
- Unexpected reply and reset:
  - Stimulus: 0xF4 answered with 0xAA.
  - Required: `err_code`=11.
  - Stimulus: new command, `reset_n` pulsed low in WAIT_ACK.
  - Required: immediate `busy`=0; no done/err tick; next `cmd_req` works normally.
- Throughout: a concurrent `cmd_req` while busy is ignored.
